sb_ddr_deser: RTL
=================

# sb_ddr_deser

Receive-side gearbox for DDR serial links. It takes the two bits per clock delivered by an `SB_IO` pad configured for DDR input (`D_IN_0`/`D_IN_1`) and finds word alignment by hunting for a sync word. Once aligned, it delivers `WIDTH`-bit words through a small FIFO with a valid/ready handshake. It is the reader for the DDR output path (`D_OUT_0`/`D_OUT_1`) of the far-end transmitter and sits between the pad primitive and user logic.

## Interface
- `WIDTH`, 8: word width in bits; must be even, 4..16.
- `SYNC`, 8'hA5: `WIDTH`-bit sync/idle word, sent MSB first.
- `LOCK_COUNT`, 2: consecutive aligned sync words required to lock; 1..7.
- `DEPTH`, 4: output FIFO entries; power of two, 2..16.
- `C`  in  1  clock; all state changes on the rising edge.
- `R`  in  1  reset, asynchronous, active-low.
- `EN`  in  1  bit-pair enable; when low, no shift, no count, no push.
- `D_IN_0`  in  1  first (earlier, rising-edge) bit of the pair.
- `D_IN_1`  in  1  second (falling-edge) bit of the pair.
- `RESYNC`  in  1  single-cycle request to drop lock and re-hunt.
- `READY`  in  1  consumer accepts the head word.
- `DATA`  out  `WIDTH`  head word of the FIFO.
- `VALID`  out  1  FIFO not empty.
- `LOCKED`  out  1  alignment established.
- `OVERFLOW`  out  1  sticky: a word was dropped because the FIFO was full.

## Operation
- Shift register `sr`, `WIDTH+1` bits, updated on each `EN` cycle: `sr <= {sr[WIDTH-2:0], D_IN_0, D_IN_1}`. The stream is MSB first, and `D_IN_0` precedes `D_IN_1`.
- Candidate windows are taken from the registered `sr`:
  - offset 0 = `sr[WIDTH-1:0]`
  - offset 1 = `sr[WIDTH:1]`
- Beat counter runs 0..`WIDTH/2-1` on `EN` cycles. A word boundary is an `EN` cycle with beat = 0. The word at that boundary is the window at the stored offset.
- FSM, with all transitions evaluated only on `EN` cycles:
  - HUNT: if either window equals `SYNC`, store that offset (offset 0 wins if both match), set beat = 1, set match count = 1, and go to VERIFY. If `LOCK_COUNT` = 1, go to LOCKED instead.
  - VERIFY: at each word boundary, a word equal to `SYNC` increments the match count. When the count reaches `LOCK_COUNT`, go to LOCKED. Any other word returns the FSM to HUNT.
  - LOCKED: at each word boundary, a word equal to `SYNC` is idle and is discarded. Any other word is pushed into the FIFO. The FSM stays in LOCKED until `RESYNC` or reset.
- `RESYNC` high (regardless of `EN`) has the following effect on the next edge:
  - FSM goes to HUNT.
  - Match count and beat are cleared.
  - FIFO contents and `OVERFLOW` are kept.
- FIFO behaviour:
  - Pop occurs when `VALID && READY`.
  - A push while full drops the word and sets `OVERFLOW`. The exception is a simultaneous pop, in which case the push is accepted and no overflow is flagged.
  - `DATA` is the head entry. It is held stable while `VALID && !READY`.
- `LOCKED` = (state == LOCKED).
- `OVERFLOW` is cleared only by reset.

## Timing
- Reset (`R` low, asynchronous):
  - `sr` = 0, beat = 0, match count = 0, state = HUNT.
  - FIFO empty.
  - `DATA` = 0, `VALID` = 0, `LOCKED` = 0, `OVERFLOW` = 0.
- On `R` deassertion, the first active edge shifts normally.
- Latency: the last pair of a data word is on the pins before edge k and lands in `sr` at k. The word is pushed at edge k+1, and `VALID` is high after k+1 (2 cycles, with `EN` held high).
- `LOCKED` rises on the edge that accepts the `LOCK_COUNT`-th sync word.
- Throughput: one word per `WIDTH/2` `EN` cycles. `READY` may stay high continuously.
- `EN` low freezes `sr`, beat and FSM. FIFO pops still occur.
- Reset asserted mid-word or mid-handshake: the in-flight word and FIFO contents are discarded.

## Test plan
- Reset check (`WIDTH`=8, `SYNC`=A5): hold `R` low with random pins, then release. Required: `VALID`=0, `LOCKED`=0, `OVERFLOW`=0, `DATA`=00.
- Even-aligned lock: send A5, A5, A5, 3C, 7E, with `READY`=1. Required:
  - `LOCKED` rises after the 2nd A5.
  - Outputs are 3C then 7E, each with `VALID` high 2 cycles after its last pair.
  - No A5 appears at the output.
- Odd-aligned lock: send a 1-bit prefix 0, then A5, A5, 96. Required: offset 1 is chosen and output 96 is observed.
- Hunt failure: send A5, 12, A5, A5, 44. Required:
  - 12 returns the FSM to HUNT and is never output.
  - Lock is reached after the later A5 pair.
  - Output is 44.
- Backpressure/overflow (`DEPTH`=4): lock, hold `READY`=0, send 01..06. Required:
  - 01..04 are stored and `OVERFLOW` goes to 1 on 05.
  - With `READY`=1, output is 01, 02, 03, 04, then `VALID`=0.
  - `OVERFLOW` stays 1.
- `RESYNC` and `EN`: while locked, pulse `RESYNC`. Required:
  - `LOCKED` falls next cycle.
  - Queued words are still delivered.
  - Data without a sync prefix is ignored.
  - `EN`=0 gaps inserted mid-word leave received values unchanged.

Source files
------------

// File: rtl/sb_ddr_deser.sv
// sb_ddr_deser: receive gearbox for a DDR pad input pair.
// Shifts two bits per enabled cycle and hunts for the sync word at either bit
// offset. Once lock is confirmed it pushes every non-sync word into a small
// output FIFO with a valid/ready handshake.
module sb_ddr_deser #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] SYNC       = 8'hA5,
  parameter int               LOCK_COUNT = 2,
  parameter int               DEPTH      = 4
) (
  input  logic             C,
  input  logic             R,
  input  logic             EN,
  input  logic             D_IN_0,
  input  logic             D_IN_1,
  input  logic             RESYNC,
  input  logic             READY,
  output logic [WIDTH-1:0] DATA,
  output logic             VALID,
  output logic             LOCKED,
  output logic             OVERFLOW
);

  localparam int HALF = WIDTH / 2;
  localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int AW   = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Alignment state
  logic [WIDTH:0]   sr_reg;
  logic [BW-1:0]    beat_reg;
  logic [2:0]       match_reg;
  logic             offset_reg;
  state_t           state_reg;

  // FIFO state
  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_idx_reg;
  logic [AW-1:0]    rd_idx_reg;
  logic [AW:0]      cnt_reg;
  logic             overflow_reg;

  // Derived signals
  logic [WIDTH-1:0] win0;
  logic [WIDTH-1:0] win1;
  logic [WIDTH-1:0] word;
  logic [BW-1:0]    beat_inc;
  logic [2:0]       match_inc;
  logic             boundary;
  logic             push;
  logic             pop;
  logic             full;
  logic             push_ok;

  // The two candidate alignments differ by one bit within the pair.
  assign win0      = sr_reg[WIDTH-1:0];
  assign win1      = sr_reg[WIDTH:1];
  assign word      = offset_reg ? win1 : win0;
  assign beat_inc  = (beat_reg == BW'(HALF - 1)) ? '0 : beat_reg + 1'b1;
  assign match_inc = match_reg + 3'd1;
  assign boundary  = EN && (beat_reg == '0);

  // A resync on the same edge wins over a push of the boundary word.
  assign push    = boundary && !RESYNC && (state_reg == ST_LOCKED) && (word != SYNC);
  assign full    = (cnt_reg == (AW+1)'(DEPTH));
  assign pop     = VALID && READY;
  assign push_ok = push && (!full || pop);

  assign VALID    = (cnt_reg != '0);
  assign DATA     = mem_reg[rd_idx_reg];
  assign LOCKED   = (state_reg == ST_LOCKED);
  assign OVERFLOW = overflow_reg;

  // Shift in one bit pair per enabled cycle, earlier bit above later bit.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      sr_reg <= '0;
    end else if (EN) begin
      sr_reg <= {sr_reg[WIDTH-2:0], D_IN_0, D_IN_1};
    end
  end

  // Alignment FSM: hunt on every pair, then confirm on word boundaries.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      state_reg  <= ST_HUNT;
      beat_reg   <= '0;
      match_reg  <= '0;
      offset_reg <= 1'b0;
    end else if (RESYNC) begin
      state_reg <= ST_HUNT;
      beat_reg  <= '0;
      match_reg <= '0;
    end else if (EN) begin
      beat_reg <= beat_inc;
      case (state_reg)
        ST_HUNT: begin
          if ((win0 == SYNC) || (win1 == SYNC)) begin
            // Offset 0 takes priority when both windows match.
            offset_reg <= (win0 != SYNC);
            beat_reg   <= BW'(1);
            match_reg  <= 3'd1;
            state_reg  <= (LOCK_COUNT == 1) ? ST_LOCKED : ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (boundary) begin
            if (word == SYNC) begin
              match_reg <= match_inc;
              if (match_inc >= 3'(LOCK_COUNT)) begin
                state_reg <= ST_LOCKED;
              end
            end else begin
              match_reg <= '0;
              state_reg <= ST_HUNT;
            end
          end
        end
        ST_LOCKED: begin
          state_reg <= ST_LOCKED;
        end
        default: begin
          state_reg <= ST_HUNT;
        end
      endcase
    end
  end

  // FIFO storage: one register per entry, written when the write pointer selects it.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
    // Capture the boundary word into this entry on an accepted push.
    always_ff @(posedge C or negedge R) begin
      if (!R) begin
        mem_reg[gi] <= '0;
      end else if (push_ok && (wr_idx_reg == AW'(gi))) begin
        mem_reg[gi] <= word;
      end
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      wr_idx_reg   <= '0;
      rd_idx_reg   <= '0;
      cnt_reg      <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_idx_reg <= wr_idx_reg + 1'b1;
      end
      if (pop) begin
        rd_idx_reg <= rd_idx_reg + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   cnt_reg <= cnt_reg + 1'b1;
        2'b01:   cnt_reg <= cnt_reg - 1'b1;
        default: cnt_reg <= cnt_reg;
      endcase
      if (push && !push_ok) begin
        overflow_reg <= 1'b1;
      end
    end
  end

endmodule
